csa_pipe_addsub: RTL and testbench

- Parametrised, 2-stage pipelined carry-select adder/subtractor for the MIPS pipelined CPU datapath (ALU add/sub, address generation).
- Generalises the fixed 32-bit two-half carry-select adder to WIDTH bits split into SEG-bit segments.
- Adds a subtract mode, status flags, and a valid/ready handshake with back-pressure.

---
 rtl/csa_pipe_addsub_pkg.sv | 22 ++
 rtl/csa_pipe_addsub_seg.sv | 15 +
 rtl/csa_pipe_addsub.sv | 147 ++++++++++++++
 tb/tb_csa_pipe_addsub.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_pipe_addsub_pkg.sv
// Shared defaults, operating-mode encoding and parameter helpers for the
// pipelined carry-select adder/subtractor.
package csa_pipe_addsub_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SEG   = 8;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

    // Carry into bit 0: subtract is A + ~B + 1, so the external carry is ignored.
    function automatic logic first_cin(input mode_e mode, input logic carry_in);
        return (mode == MODE_SUB) ? 1'b1 : carry_in;
    endfunction

    function automatic bit params_ok(input int width, input int seg);
        return (seg >= 2) && (width >= seg) && ((width % seg) == 0);
    endfunction

endpackage

// File: rtl/csa_pipe_addsub_seg.sv
// SEG-bit ripple segment; the carry-in comes from a port so the same block
// serves both fixed-carry candidates and the live segment 0.
module csa_pipe_addsub_seg #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};

endmodule

// File: rtl/csa_pipe_addsub.sv
// Two-stage carry-select adder/subtractor with valid/ready flow control:
// stage 1 builds per-segment candidates, stage 2 resolves the select chain.
module csa_pipe_addsub
    import csa_pipe_addsub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEG   = DEF_SEG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din1,
    input  logic [WIDTH-1:0] din2,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int NSEG = WIDTH / SEG;

    if (!params_ok(WIDTH, SEG)) begin : g_bad_params
        $error("csa_pipe_addsub: WIDTH must be a multiple of SEG and SEG must be >= 2");
    end

    mode_e            mode;
    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic             adv1;
    logic             adv2;
    logic             v1;
    logic             v2;

    assign mode     = mode_e'(sub);
    assign b_eff    = (mode == MODE_SUB) ? ~din2 : din2;
    assign c0       = first_cin(mode, carry_in);

    assign adv2      = !v2 || out_ready;
    assign adv1      = !v1 || adv2;
    assign in_ready  = adv1;
    assign out_valid = v2;

    logic [NSEG-1:0][SEG-1:0] sum0_c;
    logic [NSEG-1:0][SEG-1:0] sum1_c;
    logic [NSEG-1:0]          cout0_c;
    logic [NSEG-1:0]          cout1_c;

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        if (k == 0) begin : g_first
            csa_pipe_addsub_seg #(.SEG(SEG)) u_seg (
                .a    (din1[SEG-1:0]),
                .b    (b_eff[SEG-1:0]),
                .cin  (c0),
                .sum  (sum0_c[0]),
                .cout (cout0_c[0])
            );
            // Segment 0 has a single real result; mirroring it into the
            // cin=1 slot lets stage 2 walk every segment with one loop.
            assign sum1_c[0]  = sum0_c[0];
            assign cout1_c[0] = cout0_c[0];
        end else begin : g_cand
            csa_pipe_addsub_seg #(.SEG(SEG)) u_seg0 (
                .a    (din1[k*SEG +: SEG]),
                .b    (b_eff[k*SEG +: SEG]),
                .cin  (1'b0),
                .sum  (sum0_c[k]),
                .cout (cout0_c[k])
            );
            csa_pipe_addsub_seg #(.SEG(SEG)) u_seg1 (
                .a    (din1[k*SEG +: SEG]),
                .b    (b_eff[k*SEG +: SEG]),
                .cin  (1'b1),
                .sum  (sum1_c[k]),
                .cout (cout1_c[k])
            );
        end
    end

    logic [NSEG-1:0][SEG-1:0] s1_sum0;
    logic [NSEG-1:0][SEG-1:0] s1_sum1;
    logic [NSEG-1:0]          s1_cout0;
    logic [NSEG-1:0]          s1_cout1;
    logic                     s1_a_msb;
    logic                     s1_b_msb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1       <= 1'b0;
            s1_sum0  <= '0;
            s1_sum1  <= '0;
            s1_cout0 <= '0;
            s1_cout1 <= '0;
            s1_a_msb <= 1'b0;
            s1_b_msb <= 1'b0;
        end else if (adv1) begin
            v1 <= in_valid;
            if (in_valid) begin
                s1_sum0  <= sum0_c;
                s1_sum1  <= sum1_c;
                s1_cout0 <= cout0_c;
                s1_cout1 <= cout1_c;
                s1_a_msb <= din1[WIDTH-1];
                s1_b_msb <= b_eff[WIDTH-1];
            end
        end
    end

    logic [WIDTH-1:0] res;
    logic             sel;
    logic             ovf;

    // sel starts at 0 so segment 0 picks its (only) real result; after each
    // segment sel carries that segment's resolved carry-out.
    always_comb begin
        res = '0;
        sel = 1'b0;
        for (int k = 0; k < NSEG; k++) begin
            res[k*SEG +: SEG] = sel ? s1_sum1[k] : s1_sum0[k];
            sel               = sel ? s1_cout1[k] : s1_cout0[k];
        end
        ovf = (s1_a_msb == s1_b_msb) && (res[WIDTH-1] != s1_a_msb);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2        <= 1'b0;
            dout      <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                dout      <= res;
                carry_out <= sel;
                overflow  <= ovf;
                zero      <= ~|res;
            end
        end
    end

endmodule

// File: tb/tb_csa_pipe_addsub.sv
// Directed and table-driven checks of csa_pipe_addsub at 32/8, 16/4 and 8/8.
module tb_csa_pipe_addsub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] din1, din2, dout;
    logic        carry_in, sub, carry_out, overflow, zero;

    logic        in_valid16, in_ready16, out_valid16;
    logic [15:0] din1_16, din2_16, dout16;
    logic        carry_in16, sub16, carry_out16, overflow16, zero16;

    logic        in_valid8, in_ready8, out_valid8;
    logic [7:0]  din1_8, din2_8, dout8;
    logic        carry_in8, sub8, carry_out8, overflow8, zero8;

    csa_pipe_addsub #(.WIDTH(32), .SEG(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .din1(din1), .din2(din2), .carry_in(carry_in), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready), .dout(dout),
        .carry_out(carry_out), .overflow(overflow), .zero(zero)
    );

    csa_pipe_addsub #(.WIDTH(16), .SEG(4)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .din1(din1_16), .din2(din2_16), .carry_in(carry_in16), .sub(sub16),
        .out_valid(out_valid16), .out_ready(1'b1), .dout(dout16),
        .carry_out(carry_out16), .overflow(overflow16), .zero(zero16)
    );

    csa_pipe_addsub #(.WIDTH(8), .SEG(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .din1(din1_8), .din2(din2_8), .carry_in(carry_in8), .sub(sub8),
        .out_valid(out_valid8), .out_ready(1'b1), .dout(dout8),
        .carry_out(carry_out8), .overflow(overflow8), .zero(zero8)
    );

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sb;
        logic [31:0] d;
        logic        c;
        logic        ov;
        logic        z;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic        c;
        logic        ov;
        logic        z;
    } res_t;

    int n_pass  = 0;
    int n_total = 0;

    vec_t vecs[12];
    vec_t p16[3];
    vec_t p8[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference built from plain integer arithmetic, independent of the segment structure.
    function automatic res_t ref_op(input logic [31:0] a, input logic [31:0] b,
                                    input logic cin, input logic sb);
        res_t   r;
        longint s;
        logic [32:0] u;
        if (sb) begin
            r.d = a - b;
            r.c = (a >= b);
            s   = longint'($signed(a)) - longint'($signed(b));
        end else begin
            u   = {1'b0, a} + {1'b0, b} + {32'd0, cin};
            r.d = u[31:0];
            r.c = u[32];
            s   = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
        end
        r.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        r.z  = (r.d == 32'd0);
        return r;
    endfunction

    task automatic run_vec(input vec_t v);
        @(posedge clk); #1;
        din1 = v.a; din2 = v.b; carry_in = v.cin; sub = v.sb;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; din1 = ~v.a; din2 = ~v.b;
        @(negedge clk);
        check({v.name, "/lat1_valid"}, out_valid, 0);
        @(posedge clk);
        @(negedge clk);
        check({v.name, "/valid"}, out_valid, 1);
        check({v.name, "/dout"}, dout, v.d);
        check({v.name, "/carry"}, carry_out, v.c);
        check({v.name, "/ovf"}, overflow, v.ov);
        check({v.name, "/zero"}, zero, v.z);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] ta[16], tb_v[16];
        logic        tc[16], ts[16];
        res_t        te[16];
        int          idx, got;
        logic [31:0] exp_d;

        vecs[0]  = '{"add_ff_1",  32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{"add_prop",  32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{"sub_5_7",   32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{"sub_min",   32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{"add_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{"sub_eq",    32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{"add_seg1",  32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{"sub_cin",   32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{"add_neg",   32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
        vecs[9]  = '{"add_mix",   32'h00FF_00FF, 32'h0001_0001, 1'b1, 1'b0, 32'h0100_0101, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{"sub_0_1",   32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{"add_all1",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};

        p16[0] = '{"w16_prop", 32'hFFFF, 32'h0000, 1'b1, 1'b0, 32'h0000, 1'b1, 1'b0, 1'b1};
        p16[1] = '{"w16_sub",  32'h8000, 32'h0001, 1'b0, 1'b1, 32'h7FFF, 1'b1, 1'b1, 1'b0};
        p16[2] = '{"w16_add",  32'h00FF, 32'h0001, 1'b0, 1'b0, 32'h0100, 1'b0, 1'b0, 1'b0};
        p8[0]  = '{"w8_ovf",   32'h7F,   32'h01,   1'b0, 1'b0, 32'h80,   1'b0, 1'b1, 1'b0};
        p8[1]  = '{"w8_wrap",  32'hFF,   32'h01,   1'b0, 1'b0, 32'h00,   1'b1, 1'b0, 1'b1};
        p8[2]  = '{"w8_sub",   32'h05,   32'h07,   1'b0, 1'b1, 32'hFE,   1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1; din1 = '0; din2 = '0; carry_in = 1'b0; sub = 1'b0;
        in_valid16 = 1'b0; din1_16 = '0; din2_16 = '0; carry_in16 = 1'b0; sub16 = 1'b0;
        in_valid8 = 1'b0; din1_8 = '0; din2_8 = '0; carry_in8 = 1'b0; sub8 = 1'b0;

        // Reset state
        #12;
        check("reset/out_valid", out_valid, 0);
        check("reset/dout", dout, 0);
        check("reset/flags", {carry_out, overflow, zero}, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset/in_ready", in_ready, 1);

        // Single beats through the table
        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // Back-to-back throughput
        for (int i = 0; i < 16; i++) begin
            ta[i]   = $urandom;
            tb_v[i] = $urandom;
            tc[i]   = 1'($urandom_range(0, 1));
            ts[i]   = 1'($urandom_range(0, 1));
            te[i]   = ref_op(ta[i], tb_v[i], tc[i], ts[i]);
        end
        for (int j = 0; j < 18; j++) begin
            @(posedge clk); #1;
            out_ready = 1'b1;
            if (j < 16) begin
                din1 = ta[j]; din2 = tb_v[j]; carry_in = tc[j]; sub = ts[j]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            check("tp/in_ready", in_ready, 1);
            if (j >= 2) begin
                check("tp/valid", out_valid, 1);
                check("tp/dout", dout, te[j-2].d);
                check("tp/carry", carry_out, te[j-2].c);
                check("tp/ovf", overflow, te[j-2].ov);
                check("tp/zero", zero, te[j-2].z);
            end
        end
        @(posedge clk);
        @(negedge clk);
        check("tp/drain", out_valid, 0);

        // Back-pressure: out_ready low for cycles 2..5
        idx = 0; got = 0;
        for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
            @(posedge clk); #1;
            out_ready = !(cyc >= 2 && cyc <= 5);
            carry_in = 1'b0; sub = 1'b0;
            in_valid = (idx < 4);
            din1 = 32'(idx + 1); din2 = 32'(idx + 1);
            @(negedge clk);
            if (cyc >= 2 && cyc <= 5) begin
                check("bp/in_ready_low", in_ready, 0);
                check("bp/held_valid", out_valid, 1);
                check("bp/held_dout", dout, 32'h2);
            end
            if (out_valid && out_ready) begin
                exp_d = 32'(2 * (got + 1));
                check("bp/order", dout, exp_d);
                got++;
            end
            if (in_valid && in_ready) idx++;
        end
        check("bp/count", 32'(got), 4);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp/no_dup", out_valid, 0);

        // Asynchronous reset with both stages full
        @(posedge clk); #1;
        din1 = 32'h8000_0000; din2 = 32'h8000_0001; carry_in = 1'b0; sub = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        din1 = 32'h1; din2 = 32'h1;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        check("rst/pre_valid", out_valid, 1);
        check("rst/pre_dout", dout, 32'h1);
        #2 rst = 1'b1;
        #1;
        check("rst/out_valid", out_valid, 0);
        check("rst/dout", dout, 0);
        check("rst/carry", carry_out, 0);
        check("rst/ovf", overflow, 0);
        check("rst/zero", zero, 0);
        @(posedge clk);
        @(negedge clk);
        check("rst/held", out_valid, 0);
        rst = 1'b0;
        #1;
        check("rst/in_ready", in_ready, 1);
        out_ready = 1'b1;
        run_vec(vecs[3]);

        // Parametric widths
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            din1_16 = p16[i].a[15:0]; din2_16 = p16[i].b[15:0];
            carry_in16 = p16[i].cin; sub16 = p16[i].sb; in_valid16 = 1'b1;
            din1_8 = p8[i].a[7:0]; din2_8 = p8[i].b[7:0];
            carry_in8 = p8[i].cin; sub8 = p8[i].sb; in_valid8 = 1'b1;
            @(posedge clk); #1;
            in_valid16 = 1'b0; in_valid8 = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check({p16[i].name, "/valid"}, out_valid16, 1);
            check({p16[i].name, "/dout"}, 32'(dout16), p16[i].d);
            check({p16[i].name, "/flags"}, {carry_out16, overflow16, zero16},
                  {p16[i].c, p16[i].ov, p16[i].z});
            check({p8[i].name, "/valid"}, out_valid8, 1);
            check({p8[i].name, "/dout"}, 32'(dout8), p8[i].d);
            check({p8[i].name, "/flags"}, {carry_out8, overflow8, zero8},
                  {p8[i].c, p8[i].ov, p8[i].z});
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
